// File: rtl/tt_issue_queue_senior_if.sv
// Issue/read bundle for the seniority issue queue.
// The master side is the OVI issue driver; the slave side is the queue itself.
interface tt_issue_queue_senior_if #(
  parameter int DEPTH    = 4,
  parameter int SB_ID_W  = 5,
  parameter int SCALAR_W = 64,
  parameter int VCSR_W   = 40
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                issue_valid;
  logic [31:0]         issue_inst;
  logic [SB_ID_W-1:0]  issue_sb_id;
  logic [SCALAR_W-1:0] issue_scalar_opnd;
  logic [VCSR_W-1:0]   issue_vcsr;
  logic                issue_vcsr_lmulb2;
  logic                dispatch_next_senior;
  logic                issue_kill;
  logic                read_req;

  logic                read_valid;
  logic [31:0]         read_issue_inst;
  logic [SB_ID_W-1:0]  read_issue_sb_id;
  logic [SCALAR_W-1:0] read_issue_scalar_opnd;
  logic [VCSR_W-1:0]   read_issue_vcsr;
  logic                read_issue_vcsr_lmulb2;
  logic                is_empty;
  logic                queue_full;
  logic [CW-1:0]       senior_count;
  logic                issue_credit;
  logic                overflow_err;
  logic                dispatch_err;

  modport master (
    output issue_valid, issue_inst, issue_sb_id,
    output issue_scalar_opnd, issue_vcsr,
    output issue_vcsr_lmulb2, dispatch_next_senior,
    output issue_kill, read_req,
    input  read_valid, read_issue_inst,
    input  read_issue_sb_id, read_issue_scalar_opnd,
    input  read_issue_vcsr, read_issue_vcsr_lmulb2,
    input  is_empty, queue_full, senior_count,
    input  issue_credit, overflow_err, dispatch_err
  );

  modport slave (
    input  issue_valid, issue_inst, issue_sb_id,
    input  issue_scalar_opnd, issue_vcsr,
    input  issue_vcsr_lmulb2, dispatch_next_senior,
    input  issue_kill, read_req,
    output read_valid, read_issue_inst,
    output read_issue_sb_id, read_issue_scalar_opnd,
    output read_issue_vcsr, read_issue_vcsr_lmulb2,
    output is_empty, queue_full, senior_count,
    output issue_credit, overflow_err, dispatch_err
  );
endinterface

// File: rtl/tt_issue_queue_senior.sv
// Issue queue with speculative writes, seniority pointer, kill and credits.
// Optional same-cycle bypass: define TT_ISSUE_Q_BYPASS_EN.
module tt_issue_queue_senior #(
  parameter int DEPTH    = 4,
  parameter int SB_ID_W  = 5,
  parameter int SCALAR_W = 64,
  parameter int VCSR_W   = 40
) (
  input logic clk,
  input logic reset,
  tt_issue_queue_senior_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0]         inst;
    logic [SB_ID_W-1:0]  sb_id;
    logic [SCALAR_W-1:0] opnd;
    logic [VCSR_W-1:0]   vcsr;
    logic                lmulb2;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] disp_ptr_q, disp_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_tot_q, cnt_tot_d;
  logic [CW-1:0] cnt_sen_q, cnt_sen_d;
  logic          credit_q, credit_d;
  logic          ovf_q, ovf_d;
  logic          derr_q, derr_d;

  entry_t        new_e, head;
  logic [CW-1:0] pending;
  logic          full, has_sen;
  logic          byp, byp_take;
  logic          wr_acc, pop, disp_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign new_e = '{
    inst:   bus.issue_inst,
    sb_id:  bus.issue_sb_id,
    opnd:   bus.issue_scalar_opnd,
    vcsr:   bus.issue_vcsr,
    lmulb2: bus.issue_vcsr_lmulb2
  };

  assign full    = (cnt_tot_q == CW'(DEPTH));
  assign has_sen = (cnt_sen_q != '0);
  assign pending = cnt_tot_q - cnt_sen_q;

`ifdef TT_ISSUE_Q_BYPASS_EN
  // Bypass only when nothing older is held, so order is preserved.
  assign byp = (cnt_tot_q == '0) && bus.issue_valid
            && bus.dispatch_next_senior && !bus.issue_kill;
`else
  assign byp = 1'b0;
`endif
  assign byp_take = byp && bus.read_req;

  assign wr_acc  = bus.issue_valid && !full && !byp_take;
  assign pop     = bus.read_req && has_sen;
  assign disp_ok = bus.dispatch_next_senior && !byp_take
                && ((pending != '0) || wr_acc);

  always_comb begin
    wr_ptr_d   = wr_acc  ? inc(wr_ptr_q)   : wr_ptr_q;
    disp_ptr_d = disp_ok ? inc(disp_ptr_q) : disp_ptr_q;
    rd_ptr_d   = pop     ? inc(rd_ptr_q)   : rd_ptr_q;
    cnt_sen_d  = cnt_sen_q + CW'(disp_ok) - CW'(pop);
    cnt_tot_d  = cnt_tot_q + CW'(wr_acc) - CW'(pop);
    credit_d   = pop || byp_take;
    ovf_d      = bus.issue_valid && full;
    derr_d     = bus.dispatch_next_senior
              && !disp_ok && !byp_take;
    // Kill applies after dispatch: only post-dispatch seniors survive.
    if (bus.issue_kill) begin
      wr_ptr_d  = disp_ptr_d;
      cnt_tot_d = cnt_sen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      disp_ptr_q <= '0;
      rd_ptr_q   <= '0;
      cnt_tot_q  <= '0;
      cnt_sen_q  <= '0;
      credit_q   <= 1'b0;
      ovf_q      <= 1'b0;
      derr_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      disp_ptr_q <= disp_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_tot_q  <= cnt_tot_d;
      cnt_sen_q  <= cnt_sen_d;
      credit_q   <= credit_d;
      ovf_q      <= ovf_d;
      derr_q     <= derr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= new_e;
  end

  always_comb begin
    head = '0;
    if (byp)          head = new_e;
    else if (has_sen) head = mem_q[rd_ptr_q];
  end

  assign bus.read_valid             = has_sen || byp;
  assign bus.read_issue_inst        = head.inst;
  assign bus.read_issue_sb_id       = head.sb_id;
  assign bus.read_issue_scalar_opnd = head.opnd;
  assign bus.read_issue_vcsr        = head.vcsr;
  assign bus.read_issue_vcsr_lmulb2 = head.lmulb2;
  assign bus.is_empty               = (cnt_tot_q == '0);
  assign bus.queue_full             = full;
  assign bus.senior_count           = cnt_sen_q;
  assign bus.issue_credit           = credit_q;
  assign bus.overflow_err           = ovf_q;
  assign bus.dispatch_err           = derr_q;
endmodule

// File: tb/tb_tt_issue_queue_senior.sv
// Bench for tt_issue_queue_senior: directed table, wrap sequence, random vs queue model.
// Covers the TT_ISSUE_Q_BYPASS_EN build when that macro is defined.
module tb_tt_issue_queue_senior;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tt_issue_queue_senior_if #(.DEPTH(4)) bi ();
  tt_issue_queue_senior_if #(.DEPTH(3)) b3 ();

  tt_issue_queue_senior #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bi.slave)
  );
  tt_issue_queue_senior #(.DEPTH(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3.slave)
  );

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  sb;
    logic [63:0] op;
    logic [39:0] vc;
    logic        lm;
  } ent_t;

  typedef struct {
    bit iv; logic [31:0] inst;
    bit disp; bit kill; bit req;
    bit rv; logic [31:0] rinst;
    bit em; bit fu; int sc;
    bit cr; bit ov; bit de;
  } vec_t;

  vec_t tbl[16];
  ent_t mq[$];
  int   msen;
  bit   e_cr, e_ov, e_de;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bi.issue_valid = 0; bi.issue_inst = '0;
    bi.issue_sb_id = '0; bi.issue_scalar_opnd = '0;
    bi.issue_vcsr = '0; bi.issue_vcsr_lmulb2 = 0;
    bi.dispatch_next_senior = 0; bi.issue_kill = 0;
    bi.read_req = 0;
    b3.issue_valid = 0; b3.issue_inst = '0;
    b3.issue_sb_id = '0; b3.issue_scalar_opnd = '0;
    b3.issue_vcsr = '0; b3.issue_vcsr_lmulb2 = 0;
    b3.dispatch_next_senior = 0; b3.issue_kill = 0;
    b3.read_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1 idle();
    @(negedge clk);
  endtask

  function automatic vec_t mk(
    bit iv, logic [31:0] inst, bit disp, bit kill, bit req,
    bit rv, logic [31:0] ri, bit em, bit fu, int sc,
    bit cr, bit ov, bit de);
    vec_t v;
    v.iv = iv; v.inst = inst; v.disp = disp;
    v.kill = kill; v.req = req; v.rv = rv;
    v.rinst = ri; v.em = em; v.fu = fu; v.sc = sc;
    v.cr = cr; v.ov = ov; v.de = de;
    return v;
  endfunction

  // Reference: ordered list of entries, oldest msen of them senior.
  task automatic model(input bit iv, input ent_t e,
                       input bit disp, input bit kill,
                       input bit req);
    bit full, bt, pop, wr, dok;
    int pend;
    full = (mq.size() == 4);
    bt = 0;
`ifdef TT_ISSUE_Q_BYPASS_EN
    bt = (mq.size() == 0) && iv && disp && !kill && req;
`endif
    pop  = req && (msen > 0);
    wr   = iv && !full && !bt;
    pend = mq.size() - msen;
    dok  = disp && !bt && (pend > 0 || wr);
    e_cr = pop || bt;
    e_ov = iv && full;
    e_de = disp && !dok && !bt;
    if (pop) begin void'(mq.pop_front()); msen--; end
    if (wr) mq.push_back(e);
    if (dok) msen++;
    if (kill) while (mq.size() > msen) void'(mq.pop_back());
  endtask

  task automatic chk_model(input string nm);
    ent_t h;
    h = '{default: '0};
    if (msen > 0) h = mq[0];
    chk({nm, ".rv"}, 64'(bi.read_valid), 64'(msen > 0));
    chk({nm, ".inst"}, 64'(bi.read_issue_inst), 64'(h.inst));
    chk({nm, ".sb"}, 64'(bi.read_issue_sb_id), 64'(h.sb));
    chk({nm, ".op"}, bi.read_issue_scalar_opnd, h.op);
    chk({nm, ".vc"}, 64'(bi.read_issue_vcsr), 64'(h.vc));
    chk({nm, ".lm"}, 64'(bi.read_issue_vcsr_lmulb2), 64'(h.lm));
    chk({nm, ".empty"}, 64'(bi.is_empty), 64'(mq.size() == 0));
    chk({nm, ".full"}, 64'(bi.queue_full), 64'(mq.size() == 4));
    chk({nm, ".sc"}, 64'(bi.senior_count), 64'(msen));
    chk({nm, ".credit"}, 64'(bi.issue_credit), 64'(e_cr));
    chk({nm, ".ovf"}, 64'(bi.overflow_err), 64'(e_ov));
    chk({nm, ".derr"}, 64'(bi.dispatch_err), 64'(e_de));
  endtask

  initial begin
    ent_t e;
    bit iv, dp, kl, rq;

    idle();
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);

    chk("rst.rv", 64'(bi.read_valid), 0);
    chk("rst.inst", 64'(bi.read_issue_inst), 0);
    chk("rst.empty", 64'(bi.is_empty), 1);
    chk("rst.full", 64'(bi.queue_full), 0);
    chk("rst.sc", 64'(bi.senior_count), 0);
    chk("rst.pulses", 64'({bi.issue_credit,
        bi.overflow_err, bi.dispatch_err}), 0);

    tbl[0]  = mk(1, 32'hA1, 1, 0, 0, 1, 32'hA1, 0, 0, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0,      0, 0, 1, 0, 0,      1, 0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0,      1, 0, 0, 0, 0,      1, 0, 0, 0, 0, 1);
    tbl[3]  = mk(1, 32'hB0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 32'hB1, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 32'hB2, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 32'hB3, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0, 0);
    tbl[7]  = mk(1, 32'hBF, 0, 0, 0, 0, 0,      0, 1, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0,      1, 0, 0, 1, 32'hB0, 0, 1, 1, 0, 0, 0);
    tbl[9]  = mk(0, 0,      1, 0, 0, 1, 32'hB0, 0, 1, 2, 0, 0, 0);
    tbl[10] = mk(0, 0,      0, 1, 0, 1, 32'hB0, 0, 0, 2, 0, 0, 0);
    tbl[11] = mk(0, 0,      0, 0, 1, 1, 32'hB1, 0, 0, 1, 1, 0, 0);
    tbl[12] = mk(0, 0,      0, 0, 1, 0, 0,      1, 0, 0, 1, 0, 0);
    tbl[13] = mk(1, 32'hC0, 1, 1, 0, 1, 32'hC0, 0, 0, 1, 0, 0, 0);
    tbl[14] = mk(1, 32'hD0, 0, 1, 0, 1, 32'hC0, 0, 0, 1, 0, 0, 0);
    tbl[15] = mk(0, 0,      0, 0, 1, 0, 0,      1, 0, 0, 1, 0, 0);

    for (int i = 0; i < 16; i++) begin
      bi.issue_valid = tbl[i].iv;
      bi.issue_inst = tbl[i].inst;
      bi.issue_sb_id = tbl[i].inst[4:0];
      bi.dispatch_next_senior = tbl[i].disp;
      bi.issue_kill = tbl[i].kill;
      bi.read_req = tbl[i].req;
      step();
      chk($sformatf("v%0d.rv", i), 64'(bi.read_valid), 64'(tbl[i].rv));
      chk($sformatf("v%0d.inst", i), 64'(bi.read_issue_inst), 64'(tbl[i].rinst));
      chk($sformatf("v%0d.empty", i), 64'(bi.is_empty), 64'(tbl[i].em));
      chk($sformatf("v%0d.full", i), 64'(bi.queue_full), 64'(tbl[i].fu));
      chk($sformatf("v%0d.sc", i), 64'(bi.senior_count), 64'(tbl[i].sc));
      chk($sformatf("v%0d.credit", i), 64'(bi.issue_credit), 64'(tbl[i].cr));
      chk($sformatf("v%0d.ovf", i), 64'(bi.overflow_err), 64'(tbl[i].ov));
      chk($sformatf("v%0d.derr", i), 64'(bi.dispatch_err), 64'(tbl[i].de));
    end

`ifdef TT_ISSUE_Q_BYPASS_EN
    bi.issue_valid = 1; bi.issue_inst = 32'hE0;
    bi.dispatch_next_senior = 1; bi.read_req = 1;
    #1;
    chk("byp.rv", 64'(bi.read_valid), 1);
    chk("byp.inst", 64'(bi.read_issue_inst), 32'hE0);
    step();
    chk("byp.empty", 64'(bi.is_empty), 1);
    chk("byp.rv_after", 64'(bi.read_valid), 0);
    chk("byp.credit", 64'(bi.issue_credit), 1);
`endif

    // DEPTH=3 wrap: one in, one out per cycle across two wraps.
    b3.issue_valid = 1; b3.issue_sb_id = 5'd0;
    b3.issue_inst = 32'd100; b3.dispatch_next_senior = 1;
    step();
    chk("wrap.rv0", 64'(b3.read_valid), 1);
    chk("wrap.sb0", 64'(b3.read_issue_sb_id), 0);
    for (int i = 1; i < 7; i++) begin
      b3.issue_valid = 1; b3.issue_sb_id = 5'(i);
      b3.issue_inst = 32'(100 + i);
      b3.dispatch_next_senior = 1; b3.read_req = 1;
      step();
      chk($sformatf("wrap.sb%0d", i), 64'(b3.read_issue_sb_id), 64'(i));
      chk($sformatf("wrap.inst%0d", i), 64'(b3.read_issue_inst), 64'(100 + i));
      chk($sformatf("wrap.sc%0d", i), 64'(b3.senior_count), 1);
      chk($sformatf("wrap.cr%0d", i), 64'(b3.issue_credit), 1);
    end
    b3.read_req = 1;
    step();
    chk("wrap.empty", 64'(b3.is_empty), 1);
    chk("wrap.credit", 64'(b3.issue_credit), 1);

    mq.delete(); msen = 0;
    for (int n = 0; n < 3000; n++) begin
      iv = ($urandom_range(0, 9) < 6);
      dp = ($urandom_range(0, 9) < 4);
      kl = ($urandom_range(0, 19) == 0);
      rq = ($urandom_range(0, 9) < 4);
      e.inst = $urandom();
      e.sb = 5'($urandom());
      e.op = {$urandom(), $urandom()};
      e.vc = 40'({$urandom(), $urandom()});
      e.lm = 1'($urandom());
      bi.issue_valid = iv; bi.issue_inst = e.inst;
      bi.issue_sb_id = e.sb; bi.issue_scalar_opnd = e.op;
      bi.issue_vcsr = e.vc; bi.issue_vcsr_lmulb2 = e.lm;
      bi.dispatch_next_senior = dp; bi.issue_kill = kl;
      bi.read_req = rq;
      model(iv, e, dp, kl, rq);
      step();
      chk_model($sformatf("rnd%0d", n));
    end

    bi.issue_valid = 1; bi.issue_inst = 32'h77;
    bi.dispatch_next_senior = 1;
    step();
    reset = 1;
    step();
    reset = 0;
    chk("rst2.empty", 64'(bi.is_empty), 1);
    chk("rst2.rv", 64'(bi.read_valid), 0);
    chk("rst2.sc", 64'(bi.senior_count), 0);
    chk("rst2.inst", 64'(bi.read_issue_inst), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
